// File: rtl/pc_conf_readback.sv
// pc_conf_readback: upstream (FPGA->PC) readback of the configuration register file.
// A request {start_idx, count} snapshots count+1 consecutive registers, wrapping
// modulo Nreg, in its accept cycle. The snapshot is then sent out one register per
// word as {READBACK_CODE, idx, data}. The upstream channel may stall at any time.
module pc_conf_readback #(
    parameter int                Nconf         = 16,
    parameter int                Nreg          = 32,
    parameter int                Nidx          = 5,
    parameter int                Ncnt          = 3,
    parameter int                NPCout        = 24,
    parameter int                Ncode         = 3,
    parameter logic [Ncode-1:0]  READBACK_CODE = 3'b101
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [Nreg*Nconf-1:0]   conf_reg_out,
    input  logic [Nidx+Ncnt-1:0]    req_d,
    input  logic                    req_v,
    output logic                    req_a,
    output logic [NPCout-1:0]       out_d,
    output logic                    out_v,
    input  logic                    out_a,
    output logic                    busy,
    output logic [7:0]              bad_req_ct
);

    // Depth of the snapshot window: the largest burst is 2**Ncnt registers.
    localparam int NBUF = 2 ** Ncnt;

    // Index of the last register. Wrap is taken here, not at 2**Nidx.
    localparam logic [Nidx-1:0] LAST_IDX = Nidx'(Nreg - 1);

    // Nreg in one bit more than the index, so start_idx can be compared to it without overflow.
    localparam logic [Nidx:0] NREG_W = (Nidx + 1)'(Nreg);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              req_a_q;

    logic [Nidx-1:0]   idx_q;
    logic [Ncnt-1:0]   rem_q;
    logic [Nconf-1:0]  snap_q [NBUF];
    logic [Nconf-1:0]  snap_d [NBUF];
    logic [NPCout-1:0] out_d_q;
    logic [7:0]        bad_q;

    logic [Nconf-1:0]  reg_arr [Nreg];
    logic [Nidx-1:0]   start_idx;
    logic [Ncnt-1:0]   start_cnt;
    logic              start_ok;
    logic              req_xfer;
    logic              out_xfer;
    logic              load;
    logic              advance;
    logic              last_word;
    logic [Nidx-1:0]   idx_nxt;

    // Request fields and handshake decode.
    assign {start_idx, start_cnt} = req_d;
    assign start_ok  = ({1'b0, start_idx} < NREG_W);

    // req_a comes from its own flop. It is low while reset is held, and goes high on
    // the first edge after release. Outside reset it always equals (state_q == IDLE).
    assign req_a     = req_a_q;
    assign out_v     = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_d     = out_d_q;
    assign bad_req_ct = bad_q;

    assign req_xfer  = req_v && req_a_q;
    assign out_xfer  = out_v && out_a;

    // A good request starts a burst. A bad one is only counted.
    assign load      = (state_q == IDLE) && req_xfer && start_ok;
    assign advance   = out_xfer && (rem_q != '0);
    assign last_word = out_xfer && (rem_q == '0);

    // Index of the next word, wrapping at Nreg.
    assign idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + Nidx'(1);

    // Unpack the flat register bus into one entry per register.
    always_comb begin
        for (int i = 0; i < Nreg; i++) begin
            reg_arr[i] = conf_reg_out[i*Nconf +: Nconf];
        end
    end

    // Window as it would be captured this cycle: slot k holds register (start_idx+k) mod Nreg.
    always_comb begin
        for (int k = 0; k < NBUF; k++) begin
            snap_d[k] = reg_arr[Nidx'((int'(start_idx) + k) % Nreg)];
        end
    end

    // Next-state decode for the IDLE/SEND controller.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. req_a is registered here so it is decoded only from flops.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so each flop samples pre-edge values; blocking assignments would leak new values into later reads.
        if (reset) begin
            state_q <= IDLE;
            req_a_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_a_q <= (state_d == IDLE);
        end
    end

    // Burst bookkeeping: the current register index and how many words are left after this one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            rem_q <= '0;
        end else if (load) begin
            idx_q <= start_idx;
            rem_q <= start_cnt;
        end else if (advance) begin
            idx_q <= idx_nxt;
            rem_q <= rem_q - Ncnt'(1);
        end
    end

    // Snapshot buffer: the whole window is loaded on accept, then shifted down one slot per delivered word.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this small array is reset explicitly so the state after reset is fully defined; large RAMs are normally left unreset.
        if (reset) begin
            for (int k = 0; k < NBUF; k++) begin
                snap_q[k] <= '0;
            end
        end else if (load) begin
            snap_q <= snap_d;
        end else if (advance) begin
            for (int k = 0; k < NBUF - 1; k++) begin
                snap_q[k] <= snap_q[k+1];
            end
            snap_q[NBUF-1] <= '0;
        end
    end

    // Output word register: it changes only on accept or on a completed transfer, so it holds under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_d_q <= '0;
        end else if (load) begin
            out_d_q <= {READBACK_CODE, start_idx, snap_d[0]};
        end else if (advance) begin
            out_d_q <= {READBACK_CODE, idx_nxt, snap_q[1]};
        end else if (last_word) begin
            out_d_q <= '0;
        end
    end

    // Saturating count of requests rejected for an out-of-range start index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_q <= '0;
        end else if (req_xfer && !start_ok && (bad_q != 8'hFF)) begin
            bad_q <= bad_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_pc_conf_readback.sv
// Directed and scoreboard bench for pc_conf_readback.
// dut uses Nreg=32. dut_30 uses Nreg=30 to exercise bad indices and wrap at Nreg.
module tb_pc_conf_readback;

    localparam int NCONF  = 16;
    localparam int NREG   = 32;
    localparam int NREG30 = 30;

    logic                     clk;
    logic                     reset;
    logic [15:0]              regs [NREG];
    logic [NREG*NCONF-1:0]    conf_flat;
    logic [NREG30*NCONF-1:0]  conf_flat30;

    logic [7:0]  req_d;
    logic        req_v;
    logic        req_a;
    logic [23:0] out_d;
    logic        out_v;
    logic        out_a;
    logic        busy;
    logic [7:0]  bad_req_ct;

    logic [7:0]  req_d30;
    logic        req_v30;
    logic        req_a30;
    logic [23:0] out_d30;
    logic        out_v30;
    logic        out_a30;
    logic        busy30;
    logic [7:0]  bad_req_ct30;

    int n_checks;
    int n_fail;

    // Pack the register array onto the flat buses.
    always_comb begin
        conf_flat = '0;
        for (int i = 0; i < NREG; i++) begin
            conf_flat[i*NCONF +: NCONF] = regs[i];
        end
    end
    assign conf_flat30 = conf_flat[NREG30*NCONF-1:0];

    pc_conf_readback dut (
        .clk          (clk),
        .reset        (reset),
        .conf_reg_out (conf_flat),
        .req_d        (req_d),
        .req_v        (req_v),
        .req_a        (req_a),
        .out_d        (out_d),
        .out_v        (out_v),
        .out_a        (out_a),
        .busy         (busy),
        .bad_req_ct   (bad_req_ct)
    );

    pc_conf_readback #(.Nreg(NREG30)) dut_30 (
        .clk          (clk),
        .reset        (reset),
        .conf_reg_out (conf_flat30),
        .req_d        (req_d30),
        .req_v        (req_v30),
        .req_a        (req_a30),
        .out_d        (out_d30),
        .out_v        (out_v30),
        .out_a        (out_a30),
        .busy         (busy30),
        .bad_req_ct   (bad_req_ct30)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic restore_regs;
        for (int i = 0; i < NREG; i++) begin
            regs[i] = 16'h1000 + 16'(i);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_v = 1'b1;
        req_d = {5'd7, 3'd0};
        repeat (2) @(negedge clk);
        n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL reset_req_a: got %b want 0", req_a); end
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v: got %b want 0", out_v); end
        n_checks++; if (out_d !== 24'h0) begin n_fail++; $display("FAIL reset_out_d: got %h want 000000", out_d); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (bad_req_ct !== 8'd0) begin n_fail++; $display("FAIL reset_bad_ct: got %0d want 0", bad_req_ct); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_a: got %b want 1", req_a); end
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_v: got %b want 0", out_v); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        n_checks++; if (req_a30 !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_a30: got %b want 1", req_a30); end
        req_v = 1'b0;
        @(negedge clk);
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_no_xfer_out_v: got %b want 0", out_v); end
    endtask

    task automatic test_single_read;
        regs[7] = 16'hBEEF;
        out_a   = 1'b1;
        n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL single_pre_req_a: got %b want 1", req_a); end
        req_v = 1'b1;
        req_d = {5'd7, 3'd0};
        @(negedge clk);
        req_v = 1'b0;
        n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL single_out_v: got %b want 1", out_v); end
        n_checks++; if (out_d !== 24'hA7BEEF) begin n_fail++; $display("FAIL single_out_d: got %h want A7BEEF", out_d); end
        n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL single_req_a_busy: got %b want 0", req_a); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL single_done_out_v: got %b want 0", out_v); end
        n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL single_done_req_a: got %b want 1", req_a); end
        @(negedge clk);
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL single_one_word: got out_v %b want 0", out_v); end
        regs[7] = 16'h1007;
    endtask

    task automatic test_burst_wrap;
        logic [23:0] exp_w [4];
        exp_w[0] = 24'hBE101E;
        exp_w[1] = 24'hBF101F;
        exp_w[2] = 24'hA01000;
        exp_w[3] = 24'hA11001;
        out_a = 1'b1;
        req_v = 1'b1;
        req_d = {5'd30, 3'd3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_v = 1'b0;
            n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL wrap_out_v[%0d]: got %b want 1", i, out_v); end
            n_checks++; if (out_d !== exp_w[i]) begin n_fail++; $display("FAIL wrap_out_d[%0d]: got %h want %h", i, out_d, exp_w[i]); end
        end
        @(negedge clk);
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL wrap_idle_out_v: got %b want 0", out_v); end
        n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL wrap_idle_req_a: got %b want 1", req_a); end
    endtask

    task automatic test_snapshot_backpressure;
        out_a = 1'b0;
        req_v = 1'b1;
        req_d = {5'd4, 3'd1};
        @(negedge clk);
        req_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL snap_hold_out_v[%0d]: got %b want 1", i, out_v); end
            n_checks++; if (out_d !== 24'hA41004) begin n_fail++; $display("FAIL snap_hold_out_d[%0d]: got %h want A41004", i, out_d); end
            n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL snap_hold_req_a[%0d]: got %b want 0", i, req_a); end
            regs[4] = 16'h4A00 + 16'(i);
            regs[5] = 16'h5B00 + 16'(i);
            @(negedge clk);
        end
        out_a = 1'b1;
        @(negedge clk);
        n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL snap_second_out_v: got %b want 1", out_v); end
        n_checks++; if (out_d !== 24'hA51005) begin n_fail++; $display("FAIL snap_second_out_d: got %h want A51005", out_d); end
        @(negedge clk);
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL snap_end_out_v: got %b want 0", out_v); end
        restore_regs();
    endtask

    task automatic test_back_to_back;
        logic        exp_v  [6];
        logic [23:0] exp_dd [6];
        exp_v[0] = 1'b1; exp_dd[0] = 24'hA21002;
        exp_v[1] = 1'b1; exp_dd[1] = 24'hA31003;
        exp_v[2] = 1'b0; exp_dd[2] = 24'h0;
        exp_v[3] = 1'b1; exp_dd[3] = 24'hA21002;
        exp_v[4] = 1'b1; exp_dd[4] = 24'hA31003;
        exp_v[5] = 1'b0; exp_dd[5] = 24'h0;
        out_a = 1'b1;
        req_v = 1'b1;
        req_d = {5'd2, 3'd1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (out_v !== exp_v[i]) begin n_fail++; $display("FAIL b2b_out_v[%0d]: got %b want %b", i, out_v, exp_v[i]); end
            n_checks++; if (req_a !== ~exp_v[i]) begin n_fail++; $display("FAIL b2b_req_a[%0d]: got %b want %b", i, req_a, ~exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++; if (out_d !== exp_dd[i]) begin n_fail++; $display("FAIL b2b_out_d[%0d]: got %h want %h", i, out_d, exp_dd[i]); end
            end
        end
        req_v = 1'b0;
        @(negedge clk);
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL b2b_end_out_v: got %b want 0", out_v); end
    endtask

    task automatic test_bad_index;
        bit seen_v;
        seen_v  = 1'b0;
        out_a30 = 1'b1;
        req_v30 = 1'b1;
        req_d30 = {5'd31, 3'd2};
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (out_v30 !== 1'b0) seen_v = 1'b1;
            if (n == 1) begin
                n_checks++; if (bad_req_ct30 !== 8'd1) begin n_fail++; $display("FAIL bad_ct_first: got %0d want 1", bad_req_ct30); end
                n_checks++; if (req_a30 !== 1'b1) begin n_fail++; $display("FAIL bad_req_a: got %b want 1", req_a30); end
            end
            if (n == 254) begin
                n_checks++; if (bad_req_ct30 !== 8'd254) begin n_fail++; $display("FAIL bad_ct_254: got %0d want 254", bad_req_ct30); end
            end
            if (n == 300) begin
                n_checks++; if (bad_req_ct30 !== 8'd255) begin n_fail++; $display("FAIL bad_ct_sat: got %0d want 255", bad_req_ct30); end
            end
        end
        req_v30 = 1'b0;
        n_checks++; if (seen_v !== 1'b0) begin n_fail++; $display("FAIL bad_no_out_v: got out_v seen %b want 0", seen_v); end
        // Index 29 is the last register when Nreg is 30, so the next word is index 0.
        req_v30 = 1'b1;
        req_d30 = {5'd29, 3'd1};
        @(negedge clk);
        req_v30 = 1'b0;
        n_checks++; if (out_d30 !== 24'hBD101D) begin n_fail++; $display("FAIL wrap30_first: got %h want BD101D", out_d30); end
        @(negedge clk);
        n_checks++; if (out_d30 !== 24'hA01000) begin n_fail++; $display("FAIL wrap30_second: got %h want A01000", out_d30); end
        @(negedge clk);
        n_checks++; if (out_v30 !== 1'b0) begin n_fail++; $display("FAIL wrap30_end: got out_v %b want 0", out_v30); end
    endtask

    task automatic test_stress;
        logic [23:0] exp_q [$];
        logic        m_busy;
        logic        accepted;
        bit          did_reset;
        int          expected_words;
        int          seen_words;
        logic [4:0]  s_idx;
        logic [2:0]  s_cnt;
        int          ri;
        m_busy = 1'b0; accepted = 1'b0; did_reset = 1'b0;
        expected_words = 0; seen_words = 0;
        req_v = 1'b0; out_a = 1'b0;
        for (int it = 0; it < 1700; it++) begin
            n_checks++; if (req_a !== ~m_busy) begin n_fail++; $display("FAIL stress_req_a @%0d: got %b want %b", it, req_a, ~m_busy); end
            n_checks++; if (out_v !== m_busy) begin n_fail++; $display("FAIL stress_out_v @%0d: got %b want %b", it, out_v, m_busy); end
            if (m_busy && exp_q.size() > 0) begin
                n_checks++; if (out_d !== exp_q[0]) begin n_fail++; $display("FAIL stress_out_d @%0d: got %h want %h", it, out_d, exp_q[0]); end
            end
            if (!did_reset && it >= 800 && m_busy && exp_q.size() > 1) begin
                did_reset = 1'b1;
                reset = 1'b1;
                req_v = 1'b0;
                out_a = 1'b1;
                @(negedge clk);
                n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL stress_in_reset_out_v: got %b want 0", out_v); end
                reset = 1'b0;
                @(negedge clk);
                expected_words -= exp_q.size();
                exp_q.delete();
                m_busy = 1'b0;
                continue;
            end
            if (it < 1500) begin
                if (!req_v && $urandom_range(0, 99) < 30) begin
                    req_v = 1'b1;
                    req_d = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 7))};
                end
                out_a = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 99) < 25) begin
                    ri = $urandom_range(0, NREG - 1);
                    regs[ri] = 16'($urandom);
                end
            end else begin
                out_a = 1'b1;
            end
            if (out_v === 1'b1 && out_a) seen_words++;
            if (m_busy) begin
                if (out_a) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_busy = 1'b0;
                end
            end else if (req_v) begin
                {s_idx, s_cnt} = req_d;
                for (int k = 0; k <= int'(s_cnt); k++) begin
                    exp_q.push_back({3'b101, 5'((int'(s_idx) + k) % NREG), regs[(int'(s_idx) + k) % NREG]});
                end
                expected_words += int'(s_cnt) + 1;
                m_busy = 1'b1;
                accepted = 1'b1;
            end
            @(negedge clk);
            if (accepted) begin
                req_v = 1'b0;
                accepted = 1'b0;
            end
        end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL stress_drain: burst still pending after drain budget"); end
        n_checks++; if (seen_words != expected_words) begin n_fail++; $display("FAIL stress_word_count: got %0d want %0d", seen_words, expected_words); end
        n_checks++; if (bad_req_ct !== 8'd0) begin n_fail++; $display("FAIL stress_bad_ct: got %0d want 0", bad_req_ct); end
        n_checks++; if (did_reset !== 1'b1) begin n_fail++; $display("FAIL stress_reset_hit: got %b want 1", did_reset); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req_v    = 1'b0;
        req_d    = '0;
        out_a    = 1'b1;
        req_v30  = 1'b0;
        req_d30  = '0;
        out_a30  = 1'b1;
        restore_regs();
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_snapshot_backpressure();
        test_back_to_back();
        test_bad_index();
        test_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so a stuck DUT cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
